// File: rtl/math_func_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module      : math_func_dispatch_if
// Description : Command, result and engine-side signals of math_func_dispatch.
// Revision    : 1.0
// ============================================================================
interface math_func_dispatch_if #(
    parameter int XW    = 16,
    parameter int RW    = 18,
    parameter int DEPTH = 4
);
    localparam int C_LW = $clog2(DEPTH) + 1;

    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_mode;
    logic [XW-1:0]   in_x;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_mode;
    logic [RW-1:0]   out_result;
    logic            out_err;
    logic [C_LW-1:0] fifo_level;
    logic            ea_start;
    logic [1:0]      ea_mode;
    logic [XW-1:0]   ea_x;
    logic            ea_done;
    logic [RW-1:0]   ea_result;
    logic            eb_start;
    logic [XW-1:0]   eb_x;
    logic            eb_done;
    logic [RW-1:0]   eb_result;

    modport slave (
        input  in_valid, in_mode, in_x, out_ready,
               ea_done, ea_result, eb_done, eb_result,
        output in_ready, out_valid, out_mode, out_result, out_err, fifo_level,
               ea_start, ea_mode, ea_x, eb_start, eb_x
    );

    modport master (
        output in_valid, in_mode, in_x, out_ready,
               ea_done, ea_result, eb_done, eb_result,
        input  in_ready, out_valid, out_mode, out_result, out_err, fifo_level,
               ea_start, ea_mode, ea_x, eb_start, eb_x
    );
endinterface
`default_nettype wire

// File: rtl/math_func_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : math_func_dispatch
// Description : Queued command front end dispatching to sin/cos/exp or ln(1+x)
//               engines, with registered result hold and engine timeout.
// Revision    : 1.0
// ============================================================================
module math_func_dispatch #(
    parameter int XW      = 16,
    parameter int RW      = 18,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    math_func_dispatch_if.slave bus
);
    localparam int              C_AW      = $clog2(DEPTH);
    localparam int              C_LW      = C_AW + 1;
    localparam int              C_CW      = 16;
    localparam logic [C_CW-1:0] C_TO_LAST = C_CW'(TIMEOUT - 1);
    localparam logic [1:0]      C_MODE_B  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    logic [1:0]      mode_mem_q [DEPTH];
    logic [XW-1:0]   x_mem_q    [DEPTH];
    logic [C_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [C_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [C_LW-1:0] level_q, level_d;

    state_t          state_q;
    logic [1:0]      cmd_mode_q;
    logic [XW-1:0]   cmd_x_q;
    logic [C_CW-1:0] cnt_q;
    logic            ea_start_q, eb_start_q;
    logic            out_valid_q, out_err_q;
    logic [1:0]      out_mode_q;
    logic [RW-1:0]   out_result_q;

    logic            w_full, w_empty, w_push, w_pop;
    logic [1:0]      w_head_mode;
    logic [XW-1:0]   w_head_x;
    logic            w_sel_done;
    logic [RW-1:0]   w_sel_result;

    assign w_full       = (level_q == C_LW'(DEPTH));
    assign w_empty      = (level_q == '0);
    assign w_push       = bus.in_valid && !w_full;
    assign w_pop        = (state_q == S_IDLE) && !w_empty;
    assign w_head_mode  = mode_mem_q[rd_ptr_q];
    assign w_head_x     = x_mem_q[rd_ptr_q];
    // Only the engine owning the current command is listened to.
    assign w_sel_done   = (cmd_mode_q == C_MODE_B) ? bus.eb_done   : bus.ea_done;
    assign w_sel_result = (cmd_mode_q == C_MODE_B) ? bus.eb_result : bus.ea_result;

    always_comb begin
        wr_ptr_d = w_push ? wr_ptr_q + C_AW'(1) : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + C_AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (w_push && !w_pop) begin
            level_d = level_q + C_LW'(1);
        end else if (!w_push && w_pop) begin
            level_d = level_q - C_LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mode_mem_q[wr_ptr_q] <= bus.in_mode;
            x_mem_q[wr_ptr_q]    <= bus.in_x;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cmd_mode_q   <= '0;
            cmd_x_q      <= '0;
            cnt_q        <= '0;
            ea_start_q   <= 1'b0;
            eb_start_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_err_q    <= 1'b0;
            out_mode_q   <= '0;
            out_result_q <= '0;
        end else begin
            ea_start_q <= 1'b0;
            eb_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!w_empty) begin
                        cmd_mode_q <= w_head_mode;
                        cmd_x_q    <= w_head_x;
                        // Start pulse is registered so it lines up with the ISSUE cycle.
                        ea_start_q <= (w_head_mode != C_MODE_B);
                        eb_start_q <= (w_head_mode == C_MODE_B);
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_sel_done) begin
                        out_result_q <= w_sel_result;
                        out_err_q    <= 1'b0;
                        out_mode_q   <= cmd_mode_q;
                        out_valid_q  <= 1'b1;
                        state_q      <= S_HOLD;
                    end else if (cnt_q == C_TO_LAST) begin
                        out_result_q <= '0;
                        out_err_q    <= 1'b1;
                        out_mode_q   <= cmd_mode_q;
                        out_valid_q  <= 1'b1;
                        state_q      <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_q + C_CW'(1);
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = !w_full;
    assign bus.fifo_level = level_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_mode   = out_mode_q;
    assign bus.out_result = out_result_q;
    assign bus.out_err    = out_err_q;
    assign bus.ea_start   = ea_start_q;
    assign bus.ea_mode    = cmd_mode_q;
    assign bus.ea_x       = cmd_x_q;
    assign bus.eb_start   = eb_start_q;
    assign bus.eb_x       = cmd_x_q;

endmodule
`default_nettype wire
